// File: rtl/cpu_step_ctrl_pkg.sv
// Shared mode encoding and default timing constants for the CPU step controller.
package cpu_step_ctrl_pkg;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1_000_000;
    localparam int unsigned DEFAULT_RUN_DIV         = 32'd50_000_000;

endpackage

// File: rtl/cpu_step_ctrl_input_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one raw board input.
module cpu_step_ctrl_input_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize the raw level, then accept a new level only after it has held long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= ~stable_r;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

    assign dout = stable_r;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Board-side CPU advance control: debounced single-step button or free-running divider,
// producing a one-cycle cpu_en pulse and a count of issued steps.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned RUN_DIV         = DEFAULT_RUN_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        sw_run,
    output logic        cpu_en,
    output logic        run_mode,
    output logic        btn_step_db,
    output logic [15:0] step_count
);

    localparam int unsigned      DIV_W    = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 32'd1);

    logic             btn_db_s;
    logic             sw_db_s;
    logic             btn_prev_r;
    mode_e            mode_r;
    mode_e            mode_nxt_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_adv_s;
    logic [DIV_W-1:0] div_nxt_s;
    logic             pulse_s;
    logic             en_nxt_s;
    logic             cpu_en_r;
    logic [15:0]      step_cnt_r;

    cpu_step_ctrl_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_step),
        .dout (btn_db_s)
    );

    cpu_step_ctrl_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk  (clk),
        .rst  (rst),
        .din  (sw_run),
        .dout (sw_db_s)
    );

    // Next mode, divider advance and pulse decision, all keyed off the mode held this cycle.
    always_comb begin
        mode_nxt_s = mode_r;
        div_adv_s  = {DIV_W{1'b0}};
        pulse_s    = 1'b0;
        case (mode_r)
            MODE_STEP: begin
                if (sw_db_s) mode_nxt_s = MODE_RUN;
                else         mode_nxt_s = MODE_STEP;
                pulse_s   = btn_db_s & ~btn_prev_r;
                div_adv_s = {DIV_W{1'b0}};
            end
            MODE_RUN: begin
                if (sw_db_s) mode_nxt_s = MODE_RUN;
                else         mode_nxt_s = MODE_STEP;
                if (div_r == DIV_LAST) begin
                    pulse_s   = 1'b1;
                    div_adv_s = {DIV_W{1'b0}};
                end else begin
                    pulse_s   = 1'b0;
                    div_adv_s = div_r + DIV_W'(1'b1);
                end
            end
            default: begin
                mode_nxt_s = MODE_STEP;
                pulse_s    = 1'b0;
                div_adv_s  = {DIV_W{1'b0}};
            end
        endcase
        // A mode change discards any partial divider count.
        if (mode_nxt_s != mode_r) div_nxt_s = {DIV_W{1'b0}};
        else                      div_nxt_s = div_adv_s;
        // Guard against back-to-back pulses across a RUN->STEP hand-over.
        if (cpu_en_r) en_nxt_s = 1'b0;
        else          en_nxt_s = pulse_s;
    end

    // Mode, divider, edge-detect history, pulse and step counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r     <= MODE_STEP;
            div_r      <= {DIV_W{1'b0}};
            btn_prev_r <= 1'b0;
            cpu_en_r   <= 1'b0;
            step_cnt_r <= 16'h0000;
        end else begin
            mode_r     <= mode_nxt_s;
            div_r      <= div_nxt_s;
            btn_prev_r <= btn_db_s;
            cpu_en_r   <= en_nxt_s;
            if (cpu_en_r) step_cnt_r <= step_cnt_r + 16'd1;
        end
    end

    assign cpu_en      = cpu_en_r;
    assign run_mode    = mode_r;
    assign btn_step_db = btn_db_s;
    assign step_count  = step_cnt_r;

endmodule
